// File: rtl/request_arbiter_if.sv
// Request/grant bundle between the bus monitor, the arbiter and the service sequencer.
//   master: drives req_in, mask_wr, mask_data, grant_ready; observes grant/pending/mask/timeout
//   slave : the arbiter side (inputs and outputs mirrored)
interface request_arbiter_if;
    logic [7:0] req_in;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       grant_ready;
    logic       grant_valid;
    logic [3:0] grant_index;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       timeout_err;

    modport master (
        output req_in, mask_wr, mask_data, grant_ready,
        input  grant_valid, grant_index, pending, mask, timeout_err
    );

    modport slave (
        input  req_in, mask_wr, mask_data, grant_ready,
        output grant_valid, grant_index, pending, mask, timeout_err
    );
endinterface

// File: rtl/request_arbiter.sv
// Sticky, maskable 8-line priority arbiter with a valid/ready grant and an offer timeout.
//   clk, rst : clock and synchronous active-high reset
//   bus      : request_arbiter_if.slave
//              req_in/mask_wr/mask_data/grant_ready in; grant_valid, grant_index
//              ({1'b1, position} while valid, else 0), pending, mask, timeout_err out
module request_arbiter #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    request_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {IDLE, OFFER} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_s, req_q;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [NUM_REQ-1:0]   mask_q, mask_d;
    logic [NUM_REQ-1:0]   rise, eligible, clr;
    logic [IDX_W-1:0]     sel;
    logic                 valid_q, valid_d;
    logic [IDX_W:0]       index_q, index_d;
    logic [TMR_W-1:0]     cnt_q, cnt_d;
    logic                 terr_q, terr_d;

    // Registers; req_in is sampled once before edge detection, so a rise
    // sampled at edge N lands in pending at edge N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_s     <= '0;
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            valid_q   <= 1'b0;
            index_q   <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_s     <= bus.req_in;
            req_q     <= req_s;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    // Selection, next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        index_d  = index_q;
        cnt_d    = cnt_q;
        terr_d   = 1'b0;
        clr      = '0;
        rise     = req_s & ~req_q;
        eligible = pending_q & mask_q;

        // Ascending scan: the highest set bit is the last one written.
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i]) sel = IDX_W'(i);
        end

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                index_d = '0;
                if (|eligible) begin
                    valid_d = 1'b1;
                    index_d = {1'b1, sel};
                    cnt_d   = '0;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Index is frozen for the whole offer; no pre-emption, mask writes ignored.
                if (bus.grant_ready) begin
                    clr     = NUM_REQ'(1) << index_q[IDX_W-1:0];
                    valid_d = 1'b0;
                    index_d = '0;
                    state_d = IDLE;
                end else if (cnt_q == TMR_W'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    index_d = '0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                index_d = '0;
            end
        endcase

        // A new rise on the bit being accepted keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = bus.mask_wr ? bus.mask_data : mask_q;
    end

    assign bus.grant_valid = valid_q;
    assign bus.grant_index = index_q;
    assign bus.pending     = pending_q;
    assign bus.mask        = mask_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_request_arbiter.sv
// Directed bench for request_arbiter: linear stimulus, handshake scoreboard, immediate assertions.
module tb_request_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] exp_q[$];

    request_arbiter_if bus ();

    request_arbiter #(.NUM_REQ(8), .TIMEOUT(4), .TMR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted handshake must match the next queued index.
    always @(negedge clk) begin
        if (!rst && bus.grant_valid && bus.grant_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 8'(bus.grant_index), 8'h00);
            end else begin
                chk("sb_grant_index", 8'(bus.grant_index), 8'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.req_in      = 8'h00;
        bus.mask_wr     = 1'b0;
        bus.mask_data   = 8'h00;
        bus.grant_ready = 1'b0;
        step(2);
        chk("rst_pending", bus.pending, 8'h00);
        chk("rst_mask", bus.mask, 8'hFF);
        chk("rst_valid", 8'(bus.grant_valid), 8'h00);
        chk("rst_index", 8'(bus.grant_index), 8'h00);
        chk("rst_terr", 8'(bus.timeout_err), 8'h00);
        rst = 1'b0;
        step(1);

        // Single request on bit 2, ready held high.
        bus.grant_ready = 1'b1;
        bus.req_in      = 8'h04;
        exp_q.push_back(4'hA);
        step(1);
        bus.req_in = 8'h00;
        chk("single_valid_n0", 8'(bus.grant_valid), 8'h00);
        step(1);
        chk("single_pending_set", bus.pending, 8'h04);
        chk("single_valid_n1", 8'(bus.grant_valid), 8'h00);
        step(1);
        chk("single_valid", 8'(bus.grant_valid), 8'h01);
        chk("single_index", 8'(bus.grant_index), 8'h0A);
        step(1);
        chk("single_pending_clr", bus.pending, 8'h00);
        chk("single_valid_off", 8'(bus.grant_valid), 8'h00);
        chk("single_index_off", 8'(bus.grant_index), 8'h00);

        // Priority walk: all lines held high, served 7 down to 0.
        bus.req_in = 8'hFF;
        for (int i = 7; i >= 0; i--) exp_q.push_back(4'(8 + i));
        step(2);
        chk("walk_pending_all", bus.pending, 8'hFF);
        for (int i = 7; i >= 0; i--) begin
            step(1);
            chk("walk_valid", 8'(bus.grant_valid), 8'h01);
            chk("walk_index", 8'(bus.grant_index), 8'(8 + i));
            step(1);
            chk("walk_dead_cycle", 8'(bus.grant_valid), 8'h00);
        end
        chk("walk_pending_empty", bus.pending, 8'h00);
        step(3);
        chk("walk_no_regrant", 8'(bus.grant_valid), 8'h00);
        bus.req_in = 8'h00;
        step(2);

        // Mask: upper nibble pending but disabled, then re-enabled.
        bus.mask_data = 8'h0F;
        bus.mask_wr   = 1'b1;
        step(1);
        bus.mask_wr = 1'b0;
        chk("mask_load", bus.mask, 8'h0F);
        bus.req_in = 8'hF0;
        step(1);
        bus.req_in = 8'h00;
        step(3);
        chk("mask_pending", bus.pending, 8'hF0);
        chk("mask_no_valid", 8'(bus.grant_valid), 8'h00);
        chk("mask_idle_index", 8'(bus.grant_index), 8'h00);
        for (int i = 7; i >= 4; i--) exp_q.push_back(4'(8 + i));
        bus.mask_data = 8'hFF;
        bus.mask_wr   = 1'b1;
        step(1);
        bus.mask_wr = 1'b0;
        chk("mask_restore", bus.mask, 8'hFF);
        step(1);
        chk("mask_grant_valid", 8'(bus.grant_valid), 8'h01);
        chk("mask_grant_index", 8'(bus.grant_index), 8'h0F);
        step(7);
        chk("mask_drained", bus.pending, 8'h00);
        chk("mask_drained_valid", 8'(bus.grant_valid), 8'h00);

        // Timeout on bit 1 with ready low (TIMEOUT = 4).
        bus.grant_ready = 1'b0;
        bus.req_in      = 8'h02;
        step(1);
        bus.req_in = 8'h00;
        step(2);
        chk("to_valid_c0", 8'(bus.grant_valid), 8'h01);
        chk("to_index_c0", 8'(bus.grant_index), 8'h09);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk("to_valid_held", 8'(bus.grant_valid), 8'h01);
            chk("to_index_held", 8'(bus.grant_index), 8'h09);
            chk("to_terr_low", 8'(bus.timeout_err), 8'h00);
        end
        step(1);
        chk("to_withdrawn", 8'(bus.grant_valid), 8'h00);
        chk("to_terr_pulse", 8'(bus.timeout_err), 8'h01);
        chk("to_pending_kept", bus.pending, 8'h02);
        step(1);
        chk("to_reoffer", 8'(bus.grant_valid), 8'h01);
        chk("to_reoffer_index", 8'(bus.grant_index), 8'h09);
        chk("to_terr_once", 8'(bus.timeout_err), 8'h00);

        // Collision: bit 1 rises again in the cycle it is accepted.
        bus.req_in = 8'h02;
        step(1);
        bus.req_in      = 8'h00;
        bus.grant_ready = 1'b1;
        exp_q.push_back(4'h9);
        exp_q.push_back(4'h9);
        step(1);
        chk("coll_valid_off", 8'(bus.grant_valid), 8'h00);
        chk("coll_pending_kept", bus.pending, 8'h02);
        step(1);
        chk("coll_reoffer", 8'(bus.grant_valid), 8'h01);
        chk("coll_reoffer_index", 8'(bus.grant_index), 8'h09);
        step(1);
        chk("coll_pending_clr", bus.pending, 8'h00);

        // Offer held across a mask write, then reset mid-offer.
        bus.grant_ready = 1'b0;
        bus.req_in      = 8'h80;
        step(1);
        bus.req_in = 8'h00;
        step(2);
        chk("rmo_valid", 8'(bus.grant_valid), 8'h01);
        chk("rmo_index", 8'(bus.grant_index), 8'h0F);
        bus.mask_data = 8'h00;
        bus.mask_wr   = 1'b1;
        step(1);
        bus.mask_wr = 1'b0;
        chk("rmo_mask_zero", bus.mask, 8'h00);
        chk("rmo_not_revoked", 8'(bus.grant_valid), 8'h01);
        chk("rmo_index_stable", 8'(bus.grant_index), 8'h0F);
        rst = 1'b1;
        step(1);
        chk("rmo_valid_rst", 8'(bus.grant_valid), 8'h00);
        chk("rmo_index_rst", 8'(bus.grant_index), 8'h00);
        chk("rmo_pending_rst", bus.pending, 8'h00);
        chk("rmo_mask_rst", bus.mask, 8'hFF);
        chk("rmo_terr_rst", 8'(bus.timeout_err), 8'h00);
        rst = 1'b0;
        step(2);
        chk("rmo_stay_idle", 8'(bus.grant_valid), 8'h00);

        chk("sb_empty", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
